// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   state_t    : controller states (IDLE / RUN / DONE)
//   DIV_WIDTH  : default divisor / quotient / remainder width
//   DIV_CNT_W  : width of the iteration counter for the default width
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//
// The incoming bit is shifted into the partial remainder. If the shifted value
// is at least the divisor, the step subtracts the divisor and produces quotient
// bit 1. Otherwise, the step keeps the shifted value and produces quotient bit 0.
//
// Ports:
//   rem_in   in  WIDTH  partial remainder, always < divisor on entry
//   bit_in   in  1      next dividend bit, MSB first
//   divisor  in  WIDTH  denominator
//   rem_out  out WIDTH  next partial remainder
//   q_bit    out 1      quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           unused_msbs;

    // The shifted value needs W+1 bits. Because rem_in < divisor, the shifted
    // value is always below 2*divisor. Two results follow from this.
    //   - A successful trial always fits back into WIDTH bits.
    //   - A failed trial leaves the shifted value below the divisor.
    // The sign of the trial is decided by a magnitude compare. This avoids
    // widening the subtractor by one more bit.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {1'b0, divisor};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    // By construction, the top bits of both values are zero wherever they are
    // selected, so they are intentionally dropped.
    assign unused_msbs = trial[WIDTH] ^ shifted[WIDTH];

endmodule

// File: rtl/div32_16_seq.sv
// ---------------------------------------------------------------------------
// div32_16_seq
// Iterative restoring divider that produces one quotient bit per clock.
//   dividend (2*WIDTH bits) / divisor (WIDTH bits) -> quotient, remainder
// The control handshake is start / busy / done.
//
// Build option:
//   DIV32_16_SIGNED_EN  - when defined, operands are two's complement.
//                         Magnitudes are divided.
//                         The quotient truncates toward zero.
//                         The remainder takes the sign of the dividend.
//                         Without it, the datapath is purely unsigned.
//
// Ports:
//   clk        in  1        rising-edge clock
//   rst        in  1        synchronous reset, active-high
//   start      in  1        request; honoured only in IDLE
//   dividend   in  2*WIDTH  numerator, captured when start is accepted
//   divisor    in  WIDTH    denominator, captured when start is accepted
//   busy       out 1        high while iterating
//   done       out 1        one-cycle pulse; results valid from this cycle
//   quotient   out WIDTH    result quotient
//   remainder  out WIDTH    result remainder
//   dbz        out 1        last operation divided by zero
//   ovf        out 1        last operation's quotient did not fit
// ---------------------------------------------------------------------------
module div32_16_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 dbz,
    output logic                 ovf
);

    localparam int CW = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     prem;
    logic [WIDTH-1:0]     shreg;
    logic [WIDTH-1:0]     dvsr;

    logic [2*WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]     dvsr_mag;
    logic                 accept;
    logic                 div_zero;
    logic                 pre_ovf;
    logic                 last_iter;

    logic [WIDTH-1:0]     prem_nxt;
    logic                 q_bit;
    logic [WIDTH-1:0]     q_final;
    logic [WIDTH-1:0]     q_out;
    logic [WIDTH-1:0]     r_out;
    logic                 ovf_late;

    // A request counts only while idle. A start seen in RUN or DONE is simply
    // dropped; nothing is queued.
    assign accept    = (state == S_IDLE) && start;
    assign div_zero  = (divisor == '0);
    assign pre_ovf   = (dvd_mag[2*WIDTH-1:WIDTH] >= dvsr_mag);
    assign last_iter = (state == S_RUN) && (cnt == '0);

    // The shift register starts with the low half of the dividend and feeds
    // it, MSB first, into the step. Quotient bits enter at the bottom. After
    // WIDTH steps, the register holds the quotient.
    assign q_final = {shreg[WIDTH-2:0], q_bit};

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (prem),
        .bit_in  (shreg[WIDTH-1]),
        .divisor (dvsr),
        .rem_out (prem_nxt),
        .q_bit   (q_bit)
    );

`ifdef DIV32_16_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // In signed mode, the core divides magnitudes. The most negative divisor
    // still fits, because its magnitude is 2^(WIDTH-1) taken as unsigned.
    assign dvd_mag  = dividend[2*WIDTH-1] ? (~dividend + (2*WIDTH)'(1)) : dividend;
    assign dvsr_mag = divisor[WIDTH-1] ? (~divisor + WIDTH'(1)) : divisor;

    // Both result signs are fixed at accept time. The operand inputs are not
    // meaningful after that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[2*WIDTH-1];
        end
    end

    // The sign fix-up is applied on the final iteration, so latency matches
    // the unsigned build. A negative quotient may reach 2^(WIDTH-1) in
    // magnitude. A positive quotient can reach only 2^(WIDTH-1)-1.
    always_comb begin
        q_out = neg_q ? (~q_final + WIDTH'(1)) : q_final;
        r_out = neg_r ? (~prem_nxt + WIDTH'(1)) : prem_nxt;
        if (neg_q) begin
            ovf_late = q_final[WIDTH-1] & (|q_final[WIDTH-2:0]);
        end else begin
            ovf_late = q_final[WIDTH-1];
        end
    end
`else
    assign dvd_mag  = dividend;
    assign dvsr_mag = divisor;

    // Unsigned results pass straight through, and a quotient that passed the
    // pre-check always fits.
    always_comb begin
        q_out    = q_final;
        r_out    = prem_nxt;
        ovf_late = 1'b0;
    end
`endif

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Divide-by-zero and pre-detected overflow skip RUN
    // entirely and report on the following cycle. DONE always returns to IDLE,
    // so a start held across the done pulse is taken one cycle later.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (div_zero || pre_ovf) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded directly from the state
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Datapath and result registers. Results and flags are written only at
    // accept (for the short-circuit cases) or on the last iteration. They
    // therefore hold until the next accepted start. A reset during RUN clears
    // everything, and no done pulse follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            prem      <= '0;
            shreg     <= '0;
            dvsr      <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            dvsr <= dvsr_mag;
            dbz  <= 1'b0;
            ovf  <= 1'b0;
            if (div_zero) begin
                dbz       <= 1'b1;
                quotient  <= '1;
                remainder <= dividend[WIDTH-1:0];
            end else if (pre_ovf) begin
                ovf       <= 1'b1;
                quotient  <= '0;
                remainder <= '0;
            end else begin
                prem  <= dvd_mag[2*WIDTH-1:WIDTH];
                shreg <= dvd_mag[WIDTH-1:0];
                cnt   <= CW'(WIDTH - 1);
            end
        end else if (state == S_RUN) begin
            prem  <= prem_nxt;
            shreg <= q_final;
            cnt   <= cnt - CW'(1);
            if (last_iter) begin
                ovf       <= ovf_late;
                quotient  <= ovf_late ? '0 : q_out;
                remainder <= ovf_late ? '0 : r_out;
            end
        end
    end

endmodule

// File: tb/tb_div32_16_seq.sv
// ---------------------------------------------------------------------------
// tb_div32_16_seq
// Scoreboard bench for div32_16_seq.
//
// The driver pushes the hand-computed result of each request into a queue.
// A monitor pops one entry on every done pulse and compares the DUT output
// against it. The comparison covers:
//   - the results and flags,
//   - the latency from issue to done,
//   - the division invariant.
// The expected values follow DIV32_16_SIGNED_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_div32_16_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   dividend;
    logic [15:0]   divisor;
    logic          busy;
    logic          done;
    logic [15:0]   quotient;
    logic [15:0]   remainder;
    logic          dbz;
    logic          ovf;

    typedef struct {
        string       name;
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    div32_16_seq #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    // Free-running clock, plus a cycle counter used for latency measurement
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Global watchdog, so a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, done count %0d", n_cmp);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // The division invariant, evaluated on DUT results with bench arithmetic
    function automatic bit invariant_ok(input logic [31:0] dvd, input logic [15:0] dvs,
                                        input logic [15:0] q, input logic [15:0] r);
`ifdef DIV32_16_SIGNED_EN
        longint sd = longint'($signed(dvd));
        longint sv = longint'($signed(dvs));
        longint sq = longint'($signed(q));
        longint sr = longint'($signed(r));
        longint ar = (sr < 0) ? -sr : sr;
        longint av = (sv < 0) ? -sv : sv;
        return ((sq * sv + sr) == sd) && (ar < av);
`else
        logic [63:0] prod;
        prod = {48'b0, q} * {48'b0, dvs} + {48'b0, r};
        return (prod == {32'b0, dvd}) && (r < dvs);
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check_output("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check_output({e.name, "_quotient"},  32'(quotient),  32'(e.q));
                check_output({e.name, "_remainder"}, 32'(remainder), 32'(e.r));
                check_output({e.name, "_dbz"},       32'(dbz),       32'(e.dz));
                check_output({e.name, "_ovf"},       32'(ovf),       32'(e.ov));
                check_output({e.name, "_latency"},   32'(cyc - e.issue), 32'(e.lat));
                check_output({e.name, "_busy_at_done"}, 32'(busy), 32'd0);
                if (!e.dz && !e.ov) begin
                    check_output({e.name, "_invariant"},
                                 32'(invariant_ok(e.dvd, e.dvs, quotient, remainder)), 32'd1);
                end
            end
        end
    end

    // Issue one request and record its expected response
    task automatic apply_stimulus(input string name, input logic [31:0] dvd, input logic [15:0] dvs,
                                  input logic [15:0] q, input logic [15:0] r,
                                  input logic dz, input logic ov, input int lat);
        exp_t e;
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        e.name = name; e.dvd = dvd; e.dvs = dvs; e.q = q; e.r = r;
        e.dz = dz; e.ov = ov; e.lat = lat; e.issue = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
    endtask

    // Bounded wait for done; also counts how many cycles busy was seen high
    task automatic wait_done(input string name, input int exp_busy);
        int busy_cnt = 0;
        bit seen     = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            check_output({name, "_done_timeout"}, 32'(seen), 32'd1);
        end else begin
            check_output({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        end
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input string name, input logic [31:0] dvd, input logic [15:0] dvs,
                           input logic [15:0] q, input logic [15:0] r,
                           input logic dz, input logic ov, input int lat);
        apply_stimulus(name, dvd, dvs, q, r, dz, ov, lat);
        wait_done(name, lat - 1);
    endtask

    task automatic check_cleared(input string tag);
        check_output({tag, "_busy"},      32'(busy),      32'd0);
        check_output({tag, "_done"},      32'(done),      32'd0);
        check_output({tag, "_quotient"},  32'(quotient),  32'd0);
        check_output({tag, "_remainder"}, 32'(remainder), 32'd0);
        check_output({tag, "_dbz"},       32'(dbz),       32'd0);
        check_output({tag, "_ovf"},       32'(ovf),       32'd0);
    endtask

    // Directed scenario sequence
    initial begin
        exp_t e2;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        run_vec("basic",        32'd1000,     16'd7,     16'd142,   16'd6,     1'b0, 1'b0, 17);
`ifdef DIV32_16_SIGNED_EN
        run_vec("max_product",  32'hFFFE0001, 16'hFFFF,  16'h0000,  16'h0000,  1'b0, 1'b1, 1);
`else
        run_vec("max_product",  32'hFFFE0001, 16'hFFFF,  16'hFFFF,  16'h0000,  1'b0, 1'b0, 17);
`endif
        run_vec("div_by_zero",  32'h12345678, 16'h0000,  16'hFFFF,  16'h5678,  1'b1, 1'b0, 1);
        run_vec("pre_overflow", 32'h00050000, 16'd5,     16'h0000,  16'h0000,  1'b0, 1'b1, 1);
        run_vec("zero_dividend",32'd0,        16'd3,     16'h0000,  16'h0000,  1'b0, 1'b0, 17);
        run_vec("byte_split",   32'h0000FFFF, 16'h0100,  16'h00FF,  16'h00FF,  1'b0, 1'b0, 17);
`ifdef DIV32_16_SIGNED_EN
        run_vec("max_rem",      32'hFFFEFFFF, 16'hFFFF,  16'h0000,  16'h0000,  1'b0, 1'b1, 1);
        run_vec("q_pos_limit",  32'h00008000, 16'd1,     16'h0000,  16'h0000,  1'b0, 1'b1, 17);
        run_vec("q_neg_limit",  32'hFFFF8000, 16'd1,     16'h8000,  16'h0000,  1'b0, 1'b0, 17);
        run_vec("neg_dividend", 32'hFFFFFC18, 16'd7,     16'hFF72,  16'hFFFA,  1'b0, 1'b0, 17);
        run_vec("neg_divisor",  32'd1000,     16'hFFF9,  16'hFF72,  16'h0006,  1'b0, 1'b0, 17);
`else
        run_vec("max_rem",      32'hFFFEFFFF, 16'hFFFF,  16'hFFFF,  16'hFFFE,  1'b0, 1'b0, 17);
        run_vec("q_pos_limit",  32'h00008000, 16'd1,     16'h8000,  16'h0000,  1'b0, 1'b0, 17);
        run_vec("q_neg_limit",  32'hFFFF8000, 16'd1,     16'h0000,  16'h0000,  1'b0, 1'b1, 1);
        run_vec("neg_dividend", 32'hFFFFFC18, 16'd7,     16'h0000,  16'h0000,  1'b0, 1'b1, 1);
        run_vec("neg_divisor",  32'd1000,     16'hFFF9,  16'h0000,  16'h03E8,  1'b0, 1'b0, 17);
`endif

        // A restart attempted mid-RUN must not disturb the running 1000/7.
        // The start is then held across the done pulse, so the new operands
        // are taken only on the IDLE cycle after it.
        apply_stimulus("restart_ignored", 32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 17);
        repeat (5) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd50000;
        divisor  = 16'd3;
        wait_done("restart_ignored", 11);
        e2.name = "held_start"; e2.dvd = 32'd50000; e2.dvs = 16'd3; e2.q = 16'd16666;
        e2.r = 16'd2; e2.dz = 1'b0; e2.ov = 1'b0; e2.lat = 17; e2.issue = cyc;
        sb.push_back(e2);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("held_start", 16);

        // A reset in the eighth RUN cycle aborts the operation with no done pulse
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_cleared("abort");
        repeat (25) @(posedge clk);
        #1;

        run_vec("after_reset",  32'd1000,     16'd7,     16'd142,   16'd6,     1'b0, 1'b0, 17);

        repeat (3) @(posedge clk);
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
